// File: rtl/res_acti_arb.sv
// Two-source packet arbiter merging result streams 0 and 1 into the
// activation-unit stream. Whole packets are granted round-robin, and a
// single registered output stage gives one cycle of latency at full rate.
module res_acti_arb #(
  parameter int AXI_DATA_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axis_src0_tvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axis_src0_tdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axis_src0_tkeep,
  input  logic                        s_axis_src0_tlast,
  output logic                        s_axis_src0_tready,
  input  logic                        s_axis_src1_tvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axis_src1_tdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axis_src1_tkeep,
  input  logic                        s_axis_src1_tlast,
  output logic                        s_axis_src1_tready,
  input  logic                        m_axis_res2ac_tready,
  output logic                        m_axis_res2ac_tvalid,
  output logic [AXI_DATA_WIDTH-1:0]   m_axis_res2ac_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axis_res2ac_tkeep,
  output logic                        m_axis_res2ac_tlast,
  output logic                        grant_id,
  output logic                        busy,
  output logic [15:0]                 pkt_cnt0,
  output logic [15:0]                 pkt_cnt1
);

  localparam int KEEP_W = AXI_DATA_WIDTH / 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_p0;
  logic                  grant_p0;
  logic                  last_grant_p0;
  logic [15:0]           cnt0_p0;
  logic [15:0]           cnt1_p0;

  logic                  vld_p1;
  logic [AXI_DATA_WIDTH-1:0] data_p1;
  logic [KEEP_W-1:0]     keep_p1;
  logic                  last_p1;

  logic                  take_ready;
  logic                  sel_valid;
  logic                  sel_last;
  logic [AXI_DATA_WIDTH-1:0] sel_data;
  logic [KEEP_W-1:0]     sel_keep;
  logic                  accept;

  // Round-robin choice: a lone requester wins; on contention the source
  // that was not served last wins.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  // The output stage can take a beat when empty or draining this cycle.
  assign take_ready = (state_p0 == BUSY) && !rst && (!vld_p1 || m_axis_res2ac_tready);

  assign s_axis_src0_tready = take_ready && !grant_p0;
  assign s_axis_src1_tready = take_ready &&  grant_p0;

  assign sel_valid = grant_p0 ? s_axis_src1_tvalid : s_axis_src0_tvalid;
  assign sel_last  = grant_p0 ? s_axis_src1_tlast  : s_axis_src0_tlast;
  assign sel_data  = grant_p0 ? s_axis_src1_tdata  : s_axis_src0_tdata;
  assign sel_keep  = grant_p0 ? s_axis_src1_tkeep  : s_axis_src0_tkeep;
  assign accept    = take_ready && sel_valid;

  // Stage p0: arbitration FSM, grant latch and per-source packet counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0      <= IDLE;
      grant_p0      <= 1'b0;
      last_grant_p0 <= 1'b1;
      cnt0_p0       <= 16'd0;
      cnt1_p0       <= 16'd0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (s_axis_src0_tvalid || s_axis_src1_tvalid) begin
            grant_p0 <= pick_grant(s_axis_src0_tvalid, s_axis_src1_tvalid, last_grant_p0);
            state_p0 <= BUSY;
          end
        end
        BUSY: begin
          if (accept && sel_last) begin
            state_p0      <= IDLE;
            last_grant_p0 <= grant_p0;
            if (grant_p0) cnt1_p0 <= cnt1_p0 + 16'd1;
            else          cnt0_p0 <= cnt0_p0 + 16'd1;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  // Stage p1: output register; loads on accept, empties once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      keep_p1 <= sel_keep;
      last_p1 <= sel_last;
    end else if (m_axis_res2ac_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_axis_res2ac_tvalid = vld_p1;
  assign m_axis_res2ac_tdata  = data_p1;
  assign m_axis_res2ac_tkeep  = keep_p1;
  assign m_axis_res2ac_tlast  = last_p1;
  assign grant_id             = grant_p0;
  assign busy                 = (state_p0 == BUSY);
  assign pkt_cnt0             = cnt0_p0;
  assign pkt_cnt1             = cnt1_p0;

endmodule
